// File: rtl/control_issue_encoder.sv
// Command issue encoder: buffers structured commands, packs them into decoder words,
// and presents them downstream with retry/drop handling driven by decoder feedback.
module control_issue_encoder #(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_unit_id,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_comp,
  input  logic [3:0]  cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic        flush,
  input  logic        issue_ready,
  output logic [5:0]  encoded_control,
  output logic [7:0]  data_control,
  output logic        issue_valid,
  input  logic        decode_valid,
  input  logic [1:0]  error_status,
  output logic        err_flag,
  output logic [1:0]  err_code,
  output logic [15:0] issued_count
);

  // Handshakes: a command is pushed when cmd_valid && cmd_ready at a clock edge;
  // a presented word is consumed when issue_valid && issue_ready && decode_valid.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state;
  logic [13:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [RW-1:0]   retry_cnt;

  logic            push;
  logic            accept;
  logic            drop;
  logic            pop;
  logic [13:0]     push_word;
  logic [CW-1:0]   remain;
  logic [CW-1:0]   next_count;
  logic [AW-1:0]   rd_next;
  logic [13:0]     next_word;

  assign cmd_ready = (count != CW'(DEPTH));

  always_comb begin
    push       = cmd_valid && cmd_ready;
    push_word  = {cmd_unit_id, cmd_op, cmd_comp,
                  (cmd_op == 2'b00) ? 8'h00 : {cmd_addr, 1'b1, cmd_size}};
    accept     = (state == ISSUE) && issue_ready && decode_valid;
    drop       = (state == ISSUE) && !decode_valid && (retry_cnt == RW'(MAX_RETRY - 1));
    pop        = accept || drop;
    remain     = count - CW'(pop);
    next_count = remain + CW'(push);
    rd_next    = rd_ptr + AW'(pop);
    // An entry written this edge is not yet readable, so bypass it when it becomes the head.
    next_word  = (remain == '0) ? push_word : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      retry_cnt       <= '0;
      encoded_control <= '0;
      data_control    <= '0;
      issue_valid     <= 1'b0;
      err_flag        <= 1'b0;
      err_code        <= '0;
      issued_count    <= '0;
    end else if (flush) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      retry_cnt       <= '0;
      encoded_control <= '0;
      data_control    <= '0;
      issue_valid     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= next_count;

      if (accept) begin
        retry_cnt    <= '0;
        issued_count <= issued_count + 16'd1;
      end else if (state == ISSUE && !decode_valid) begin
        if (drop) begin
          retry_cnt <= '0;
          err_flag  <= 1'b1;
          err_code  <= error_status;
        end else begin
          retry_cnt <= retry_cnt + RW'(1);
        end
      end

      if (next_count != '0) begin
        state           <= ISSUE;
        issue_valid     <= 1'b1;
        encoded_control <= next_word[13:8];
        data_control    <= next_word[7:0];
      end else begin
        state           <= IDLE;
        issue_valid     <= 1'b0;
        encoded_control <= '0;
        data_control    <= '0;
      end
    end
  end

endmodule

// File: doc/control_issue_encoder.md
Name: control_issue_encoder

Overview:
- Transmit-side counterpart of the accelerator control decoder.
- Accepts structured commands over a valid/ready interface and buffers them in a small FIFO.
- Packs each command into the 6-bit encoded_control word and the 8-bit data_control word, and holds it until the target unit accepts it.
- Monitors the decoder's decode_valid/error_status feedback in the same cycle, retrying or dropping rejected words.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- MAX_RETRY, 3, consecutive decoder rejections of one command before it is dropped; at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full; a push occurs when cmd_valid && cmd_ready.
- cmd_unit_id  in  2  target unit.
- cmd_op  in  2  00 NOP, 01 LOAD, 10 STORE, 11 COMP.
- cmd_comp  in  2  00 ADD, 01 MUL, 10 TANH, 11 RELU.
- cmd_addr  in  4  address field.
- cmd_size  in  3  size field.
- flush  in  1  synchronous FIFO clear.
- issue_ready  in  1  target unit accepts the presented word this cycle.
- encoded_control  out  6  {unit_id, op, comp}; drives the decoder.
- data_control  out  8  {addr, valid, size}; drives the decoder.
- issue_valid  out  1  a command word is presented.
- decode_valid  in  1  combinational decoder result for the presented word.
- error_status  in  2  combinational decoder error code.
- err_flag  out  1  sticky: a command was dropped.
- err_code  out  2  error_status captured at the last drop.
- issued_count  out  16  commands accepted downstream; wraps at 16 bits.

Behaviour:
- Reset (asynchronous) values:
  - FIFO empty; state IDLE; retry_cnt 0.
  - encoded_control 0, data_control 0, issue_valid 0.
  - err_flag 0, err_code 0, issued_count 0.
  - cmd_ready 1.
- Encoding is applied when the command is pushed and stored in the FIFO:
  - encoded_control = {unit_id, op, comp}.
  - NOP: data_control forced to 8'h00.
  - All other ops: data_control = {addr, 1'b1, size}; the valid bit is always 1.
  - The encoder therefore never emits a word the decoder should reject.
- Idle output: when no command is presented, drive encoded_control = 0 and data_control = 0 (a legal NOP) with issue_valid = 0.
- State machine:
  - IDLE: FIFO empty. Move to ISSUE on the edge after the first push. Latency: a push at edge N is presented in the cycle after edge N.
  - ISSUE: present the FIFO head with issue_valid = 1. Per cycle:
    - issue_ready && decode_valid: pop, issued_count += 1, retry_cnt = 0. Stay in ISSUE if more entries remain, otherwise go to IDLE.
    - !decode_valid (regardless of issue_ready): retry_cnt += 1.
      - When retry_cnt == MAX_RETRY-1: pop (drop), set err_flag, capture err_code = error_status, retry_cnt = 0.
      - Otherwise hold the word unchanged.
    - decode_valid && !issue_ready: hold the word; retry_cnt unchanged.
- Presented word stability: the outputs remain stable while held. A word changes only after a pop.
- FIFO boundary conditions:
  - cmd_ready = !full.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - When full, cmd_ready stays low until a pop; the pop cycle itself does not admit a push.
  - Pointers wrap modulo DEPTH.
- flush:
  - Empties the FIFO, zeroes retry_cnt, returns to IDLE, and drives NOP outputs in the next cycle.
  - Takes priority over a same-cycle push and pop: neither is performed and issued_count does not increment.
  - err_flag, err_code and issued_count are preserved.
- err_flag clears only on reset.
- Reset asserted mid-issue aborts immediately: outputs return to reset values asynchronously and queued commands are lost.

Test Plan:
1. Push LOAD (unit 2, addr 5, size 3) with issue_ready = 1 and decode_valid = 1:
   - required: encoded_control = 6'b100100 and data_control = 8'h5B in the cycle after the push;
   - then IDLE with outputs 0 and issued_count = 1.
2. Push NOP with addr F and size 7:
   - required: data_control = 8'h00.
   - Push COMP/RELU to unit 1: required encoded_control = 6'b011111 with data_control[3] = 1.
3. Push 5 commands back-to-back with DEPTH = 4 and issue_ready = 0:
   - required: cmd_ready falls after 4 pushes;
   - then, with issue_ready = 1: commands emerge in order, one per cycle, and issued_count = 4.
4. Hold decode_valid = 0 with error_status = 2'b01:
   - required: the same word is held for 3 cycles, then dropped;
   - err_flag = 1, err_code = 01, the next command is presented, and issued_count is unchanged.
5. Push 3 commands with issue_ready = 0, then assert flush concurrently with a new push:
   - required: next cycle FIFO empty, issue_valid = 0, cmd_ready = 1, and issued_count unchanged.
6. Deassert rst_n mid-ISSUE:
   - required: issue_valid = 0 and issued_count = 0 asynchronously;
   - after release, no stale command is presented.
